// File: rtl/rv32i_pkg.sv
// Shared RV32I control definitions: branch funct3 encodings and the
// redirect controller state type.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/br_cmp.sv
// Combinational branch-condition evaluation; funct3 010/011 are not
// branch encodings and report illegal (never taken).
module br_cmp
  import rv32i_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  fun3,
  output logic        taken,
  output logic        illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (fun3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch/jump resolution with a valid/ready PC redirect to
// fetch, misaligned-target trap and branch statistics counters.
module branch_ctrl
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_is_br,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_fun3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_rs2,
  input  logic [31:0]      ex_imm,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             flush,
  output logic             trap_misalign,
  output logic [31:0]      trap_pc,
  output logic             illegal_fun3,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             dbg_state
);

  // Handshake: a redirect transfers in the cycle where redir_valid and
  // redir_ready are both high; redir_pc is held stable until then.

  state_e            r_state;
  state_e            w_state_nxt;
  logic [31:0]       r_redir_pc;
  logic              r_trap;
  logic [31:0]       r_trap_pc;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_br_cnt;
  logic [CNT_W-1:0]  r_taken_cnt;

  logic              w_cmp_taken;
  logic              w_cmp_illegal;
  logic              w_accept;
  logic              w_taken;
  logic [31:0]       w_target;
  logic              w_aligned;

  br_cmp u_br_cmp (
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .fun3    (ex_fun3),
    .taken   (w_cmp_taken),
    .illegal (w_cmp_illegal)
  );

  assign w_accept  = ex_valid && ex_ready;
  assign w_taken   = (ex_is_br && w_cmp_taken) || ex_is_jal || ex_is_jalr;
  assign w_target  = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
  assign w_aligned = (w_target[1:0] == 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    ex_ready    = 1'b0;
    redir_valid = 1'b0;
    flush       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ex_ready = 1'b1;
        if (w_accept && w_taken && w_aligned) w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redir_valid = 1'b1;
        flush       = 1'b1;
        if (redir_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_redir_pc  <= 32'h0;
      r_trap      <= 1'b0;
      r_trap_pc   <= 32'h0;
      r_illegal   <= 1'b0;
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_trap    <= w_accept && w_taken && !w_aligned;
      r_illegal <= w_accept && ex_is_br && w_cmp_illegal;
      if (w_accept && w_taken && w_aligned) r_redir_pc <= w_target;
      if (w_accept && w_taken && !w_aligned) r_trap_pc <= ex_pc;
      if (w_accept && ex_is_br) r_br_cnt <= r_br_cnt + 1'b1;
      // Misaligned taken branches still count as taken.
      if (w_accept && ex_is_br && w_cmp_taken) r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

  assign redir_pc      = r_redir_pc;
  assign trap_misalign = r_trap;
  assign trap_pc       = r_trap_pc;
  assign illegal_fun3  = r_illegal;
  assign br_cnt        = r_br_cnt;
  assign taken_cnt     = r_taken_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl; expected values are hand-computed
// from the branch semantics and counted through a single check task.
module tb_branch_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic             ex_ready;
  logic             ex_is_br;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [2:0]       ex_fun3;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_rs1;
  logic [31:0]      ex_rs2;
  logic [31:0]      ex_imm;
  logic             redir_valid;
  logic [31:0]      redir_pc;
  logic             redir_ready;
  logic             flush;
  logic             trap_misalign;
  logic [31:0]      trap_pc;
  logic             illegal_fun3;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic             dbg_state;

  int n_checks;
  int n_errors;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_is_br      (ex_is_br),
    .ex_is_jal     (ex_is_jal),
    .ex_is_jalr    (ex_is_jalr),
    .ex_fun3       (ex_fun3),
    .ex_pc         (ex_pc),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_imm        (ex_imm),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .redir_ready   (redir_ready),
    .flush         (flush),
    .trap_misalign (trap_misalign),
    .trap_pc       (trap_pc),
    .illegal_fun3  (illegal_fun3),
    .br_cnt        (br_cnt),
    .taken_cnt     (taken_cnt),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_insn(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm);
    ex_is_br   = br;
    ex_is_jal  = jal;
    ex_is_jalr = jalr;
    ex_fun3    = f3;
    ex_pc      = pc;
    ex_rs1     = rs1;
    ex_rs2     = rs2;
    ex_imm     = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; returns #1 into cycle N+1.
  task automatic issue(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm);
    set_insn(br, jal, jalr, f3, pc, rs1, rs2, imm);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"},   32'(dbg_state),     32'd0);
    check({tag, "_rvalid"},  32'(redir_valid),   32'd0);
    check({tag, "_rpc"},     redir_pc,           32'h0);
    check({tag, "_flush"},   32'(flush),         32'd0);
    check({tag, "_exrdy"},   32'(ex_ready),      32'd1);
    check({tag, "_trap"},    32'(trap_misalign), 32'd0);
    check({tag, "_trappc"},  trap_pc,            32'h0);
    check({tag, "_illegal"}, 32'(illegal_fun3),  32'd0);
    check({tag, "_brcnt"},   32'(br_cnt),        32'd0);
    check({tag, "_tkcnt"},   32'(taken_cnt),     32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    ex_valid    = 1'b0;
    redir_ready = 1'b1;
    set_insn(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check_reset_state("rst");

    // BEQ taken, fetch ready immediately
    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
    check("beq_rvalid", 32'(redir_valid), 32'd1);
    check("beq_rpc",    redir_pc,         32'h120);
    check("beq_flush",  32'(flush),       32'd1);
    check("beq_exrdy",  32'(ex_ready),    32'd0);
    check("beq_state",  32'(dbg_state),   32'd1);
    check("beq_brcnt",  32'(br_cnt),      32'd1);
    check("beq_tkcnt",  32'(taken_cnt),   32'd1);
    step();
    check("beq_n2_exrdy",  32'(ex_ready),    32'd1);
    check("beq_n2_rvalid", 32'(redir_valid), 32'd0);

    // BLT signed: -1 < 1 taken
    issue(1'b1, 1'b0, 1'b0, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    check("blt_rvalid", 32'(redir_valid), 32'd1);
    check("blt_rpc",    redir_pc,         32'h240);
    check("blt_tkcnt",  32'(taken_cnt),   32'd2);
    step();
    // BLTU same operands: 0xFFFFFFFF < 1 false
    issue(1'b1, 1'b0, 1'b0, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    check("bltu_rvalid", 32'(redir_valid), 32'd0);
    check("bltu_exrdy",  32'(ex_ready),    32'd1);
    check("bltu_brcnt",  32'(br_cnt),      32'd3);
    check("bltu_tkcnt",  32'(taken_cnt),   32'd2);

    // Back-to-back not-taken BNE (equal operands), two accepts in two cycles
    set_insn(1'b1, 1'b0, 1'b0, 3'b001, 32'h280, 32'd7, 32'd7, 32'h8);
    ex_valid = 1'b1;
    step();
    step();
    ex_valid = 1'b0;
    check("bne_b2b_brcnt", 32'(br_cnt),      32'd5);
    check("bne_b2b_rvld",  32'(redir_valid), 32'd0);

    // JALR misaligned target 0x202
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h300, 32'h203, 32'd0, 32'h0);
    check("jalr_mis_trap",   32'(trap_misalign), 32'd1);
    check("jalr_mis_trappc", trap_pc,            32'h300);
    check("jalr_mis_rvalid", 32'(redir_valid),   32'd0);
    check("jalr_mis_flush",  32'(flush),         32'd0);
    check("jalr_mis_tkcnt",  32'(taken_cnt),     32'd2);
    step();
    check("jalr_mis_pulse", 32'(trap_misalign), 32'd0);

    // JALR 0x205 + (-1) = 0x204, bit0 cleared, aligned
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h310, 32'h205, 32'd0, 32'hFFFF_FFFF);
    check("jalr_rvalid", 32'(redir_valid), 32'd1);
    check("jalr_rpc",    redir_pc,         32'h204);
    step();

    // Misaligned taken branch: still counted as taken
    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd9, 32'd9, 32'h22);
    check("br_mis_trap",   32'(trap_misalign), 32'd1);
    check("br_mis_trappc", trap_pc,            32'h100);
    check("br_mis_brcnt",  32'(br_cnt),        32'd6);
    check("br_mis_tkcnt",  32'(taken_cnt),     32'd3);

    // BGE signed 1 >= -1 taken, fetch stalls three cycles
    redir_ready = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 3'b101, 32'h400, 32'd1, 32'hFFFF_FFFF, 32'h10);
    set_insn(1'b1, 1'b0, 1'b0, 3'b000, 32'h500, 32'd3, 32'd3, 32'h40);
    ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_rvalid", i), 32'(redir_valid), 32'd1);
      check($sformatf("stall%0d_rpc", i),    redir_pc,         32'h410);
      check($sformatf("stall%0d_flush", i),  32'(flush),       32'd1);
      check($sformatf("stall%0d_exrdy", i),  32'(ex_ready),    32'd0);
      step();
    end
    ex_valid = 1'b0;
    check("stall_brcnt", 32'(br_cnt),    32'd7);
    check("stall_tkcnt", 32'(taken_cnt), 32'd4);
    redir_ready = 1'b1;
    step();
    check("release_exrdy",  32'(ex_ready),    32'd1);
    check("release_rvalid", 32'(redir_valid), 32'd0);

    // BGEU 1 >= 0xFFFFFFFF unsigned false
    issue(1'b1, 1'b0, 1'b0, 3'b111, 32'h600, 32'd1, 32'hFFFF_FFFF, 32'h10);
    check("bgeu_rvalid", 32'(redir_valid), 32'd0);
    check("bgeu_brcnt",  32'(br_cnt),      32'd8);

    // Illegal funct3 010 with equal operands: not taken, counted
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h700, 32'd4, 32'd4, 32'h10);
    check("ill_pulse",  32'(illegal_fun3), 32'd1);
    check("ill_rvalid", 32'(redir_valid),  32'd0);
    check("ill_brcnt",  32'(br_cnt),       32'd9);
    check("ill_tkcnt",  32'(taken_cnt),    32'd4);
    step();
    check("ill_clear", 32'(illegal_fun3), 32'd0);

    // JAL wrap-around target, then reset while redirect pending
    redir_ready = 1'b0;
    issue(1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20);
    check("jal_wrap_rvalid", 32'(redir_valid), 32'd1);
    check("jal_wrap_rpc",    redir_pc,         32'h10);
    check("jal_wrap_brcnt",  32'(br_cnt),      32'd9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    redir_ready = 1'b1;
    check_reset_state("midrst");

    // Counter wrap at 2^CNT_W with back-to-back not-taken BNE
    set_insn(1'b1, 1'b0, 1'b0, 3'b001, 32'h800, 32'd1, 32'd1, 32'h8);
    ex_valid = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("wrap_brcnt_max", 32'(br_cnt), 32'd15);
    step();
    ex_valid = 1'b0;
    check("wrap_brcnt_zero", 32'(br_cnt),    32'd0);
    check("wrap_tkcnt",      32'(taken_cnt), 32'd0);

    // report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and PC-redirect controller for the RV32I execute stage. It evaluates conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and jumps (JAL/JALR) as they leave decode/execute, computes the target, and runs a valid/ready redirect handshake to the fetch unit while flushing wrong-path instructions. It also raises an instruction-address-misaligned trap and keeps branch statistics counters. The block sits between the execute stage and the fetch PC register.

## Interface
Parameters:
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a resolvable instruction this cycle.
- ex_ready  out  1  controller can accept; high only in IDLE.
- ex_is_br  in  1  conditional branch (opcode 1100011).
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_fun3  in  3  funct3 of the instruction.
- ex_pc  in  32  PC of the instruction.
- ex_rs1, ex_rs2  in  32  forwarded operand values.
- ex_imm  in  32  sign-extended immediate.
- redir_valid  out  1  redirect request to fetch.
- redir_pc  out  32  redirect target, stable while redir_valid.
- redir_ready  in  1  fetch accepts redirect.
- flush  out  1  discard IF/ID and ID/EX contents.
- trap_misalign  out  1  one-cycle pulse: target not 4-byte aligned.
- trap_pc  out  32  ex_pc of the faulting instruction, valid with trap_misalign.
- illegal_fun3  out  1  one-cycle pulse: ex_is_br with fun3 010 or 011.
- br_cnt, taken_cnt  out  CNT_W  conditional branches resolved / taken.

## Operation
- Accept: ex_valid && ex_ready. Exactly one of ex_is_br/jal/jalr is expected; none set → accepted, no action. Inputs ignored when ex_ready=0.
- Condition (ex_is_br): 000 rs1==rs2; 001 rs1!=rs2; 100 signed rs1<rs2; 101 signed rs1>=rs2; 110 unsigned <; 111 unsigned >=. 010/011 → not taken, illegal_fun3 pulse.
- Jumps always taken.
- Target: branch/JAL = ex_pc + ex_imm; JALR = (ex_rs1 + ex_imm) & ~32'h1. 32-bit add, carry discarded (wraps).
- Taken and target[1:0]==0 → load redir_pc, enter REDIRECT.
- Taken and target[1:0]!=0 → trap_misalign + trap_pc next cycle, stay IDLE, no redirect, no flush.
- Not taken → no action, stay IDLE.
- br_cnt increments on every accepted ex_is_br (including illegal fun3); taken_cnt on every accepted taken branch (including misaligned). Jumps not counted. Both wrap at 2^CNT_W.
- FSM: IDLE → REDIRECT on aligned taken accept. REDIRECT → IDLE when redir_valid && redir_ready. No other transitions.
- REDIRECT outputs: redir_valid=1, flush=1, ex_ready=0. IDLE: redir_valid=0, flush=0, ex_ready=1.

## Timing
- Reset values: state IDLE; redir_valid 0, redir_pc 0, flush 0, ex_ready 1, trap_misalign 0, trap_pc 0, illegal_fun3 0, br_cnt 0, taken_cnt 0.
- Accept in cycle N → redir_valid/flush high from N+1 (registered), trap/illegal pulses in N+1 only.
- redir_ready high in N+1 → handshake completes in N+1, IDLE and ex_ready=1 in N+2; minimum taken-branch cost 2 cycles, not-taken 0 bubbles (back-to-back accepts allowed).
- redir_ready low: hold redir_valid, redir_pc, flush indefinitely.
- redir_ready while redir_valid=0 ignored.
- rst in any cycle wins over all events: next cycle is reset state, pending redirect dropped, counters cleared.

## Structure
- Shared package rv32i_pkg: funct3 constants (F3_BEQ…F3_BGEU), state enum typedef for IDLE/REDIRECT.
- One sub-module: br_cmp (purely combinational condition evaluation from rs1, rs2, fun3 → taken, illegal). Target adder, FSM, counters in top.

## Test plan
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, redir_ready=1 → N+1 redir_valid=1, redir_pc=0x120, flush=1; N+2 ex_ready=1; br_cnt=1, taken_cnt=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU same operands → not taken, no redirect; br_cnt=2, taken_cnt=1.
- JALR rs1=0x203, imm=0 → target 0x202, trap_misalign pulse N+1, trap_pc=ex_pc, no redir_valid; JALR rs1=0x205, imm=-1 → redir_pc=0x204.
- Taken branch with redir_ready low 3 cycles → redir_valid/flush/redir_pc stable, ex_ready=0, ex_valid ignored; release → IDLE next cycle.
- fun3=010 branch → illegal_fun3 pulse, not taken, br_cnt increments; rst asserted mid-REDIRECT → all outputs at reset values next cycle.
- pc=0xFFFFFFF0, imm=0x20 JAL → redir_pc=0x00000010 (wrap); br_cnt preloaded path to 2^CNT_W-1 then one branch → 0.
